// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the multicycle RV32I controller: main FSM states,
// opcodes and the datapath select / ALU-op codes also used by the ALU decoder.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_SUB    = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_OP_PASS_B = 2'b11;

  localparam logic [1:0] RESULT_ALU_OUT    = 2'b00;
  localparam logic [1:0] RESULT_MEM_DATA   = 2'b01;
  localparam logic [1:0] RESULT_ALU_RESULT = 2'b10;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  function automatic logic is_supported_op(input logic [6:0] opcode);
    return (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_RTYPE) ||
           (opcode == OP_ITYPE) || (opcode == OP_BEQ) || (opcode == OP_JAL) ||
           (opcode == OP_LUI);
  endfunction

endpackage

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RV32I core (fetch/decode/execute/mem/writeback).
// Define MAIN_FSM_MEM_WAIT_EN to add mem_ready wait states on memory accesses.
module multicycle_main_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       zero,
`ifdef MAIN_FSM_MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q, state_d;
  logic   mem_rdy;
  logic   pc_update, branch, mem_write_s, ir_write_s, reg_write_s;

`ifdef MAIN_FSM_MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          OP_LUI:       state_d = S_LUI;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_rdy ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_LUI:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_update   = 1'b0;
    branch      = 1'b0;
    adr_src     = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    result_src  = RESULT_ALU_OUT;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_RS2;
    alu_op      = ALU_OP_ADD;
    illegal_op  = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_s = mem_rdy;
        pc_update  = mem_rdy;
        alu_src_b  = SRC_B_FOUR;
        result_src = RESULT_ALU_RESULT;
      end
      S_DECODE: begin
        alu_src_a  = SRC_A_OLD_PC;
        alu_src_b  = SRC_B_IMM;
        illegal_op = !is_supported_op(op);
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src  = RESULT_MEM_DATA;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALU_OP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_OP_FUNCT;
      end
      S_ALUWB: reg_write_s = 1'b1;
      S_BEQ: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALU_OP_SUB;
        branch    = 1'b1;
      end
      S_JAL: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_FOUR;
        pc_update = 1'b1;
      end
      S_LUI: begin
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_OP_PASS_B;
      end
      default: ;
    endcase
  end

  // Selects still show the S_FETCH values during reset, but every write enable is forced low.
  assign pc_write  = rst_n & (pc_update | (branch & zero));
  assign mem_write = rst_n & mem_write_s;
  assign ir_write  = rst_n & ir_write_s;
  assign reg_write = rst_n & reg_write_s;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Self-checking bench for multicycle_main_fsm: directed and random opcodes against
// per-instruction expected step traces; wait-state checks when MAIN_FSM_MEM_WAIT_EN is set.
module tb_multicycle_main_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic       zero;
`ifdef MAIN_FSM_MEM_WAIT_EN
  logic       mem_ready;
`endif
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [3:0] state;

  typedef logic [17:0] obs_t;

  int   n_compared   = 0;
  int   n_mismatched = 0;
  obs_t trace[$];
  obs_t observed;

  multicycle_main_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .zero       (zero),
`ifdef MAIN_FSM_MEM_WAIT_EN
    .mem_ready  (mem_ready),
`endif
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .illegal_op (illegal_op),
    .state      (state)
  );

  always #5 clk = ~clk;

  assign observed = {state, pc_write, adr_src, mem_write, ir_write, reg_write,
                     result_src, alu_src_a, alu_src_b, alu_op, illegal_op};

  function automatic obs_t mk(input logic [3:0] st, input logic pcw, input logic adr,
                              input logic mw, input logic irw, input logic rw,
                              input logic [1:0] rs, input logic [1:0] a,
                              input logic [1:0] b, input logic [1:0] aop,
                              input logic ill);
    return {st, pcw, adr, mw, irw, rw, rs, a, b, aop, ill};
  endfunction

  // Expected outputs of one named step of an instruction
  function automatic obs_t expect_for(input string name, input logic z, input logic ill);
    case (name)
      "fetch":    return mk(4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0);
      "decode":   return mk(4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, ill);
      "memadr":   return mk(4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0);
      "memread":  return mk(4'd3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      "memwb":    return mk(4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
      "memwrite": return mk(4'd5,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      "execr":    return mk(4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0);
      "execi":    return mk(4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0);
      "aluwb":    return mk(4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      "beq":      return mk(4'd9,  z,    1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0);
      "jal":      return mk(4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0);
      "lui":      return mk(4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b11, 1'b0);
      default:    return '0;
    endcase
  endfunction

  task automatic build_trace(input logic [6:0] opc, input logic z);
    string steps[$];
    logic  legal;
    legal = 1'b1;
    case (opc)
      7'b0000011: steps = '{"memadr", "memread", "memwb"};
      7'b0100011: steps = '{"memadr", "memwrite"};
      7'b0110011: steps = '{"execr", "aluwb"};
      7'b0010011: steps = '{"execi", "aluwb"};
      7'b1100011: steps = '{"beq"};
      7'b1101111: steps = '{"jal", "aluwb"};
      7'b0110111: steps = '{"lui", "aluwb"};
      default:    legal = 1'b0;
    endcase
    trace.delete();
    trace.push_back(expect_for("fetch", z, 1'b0));
    trace.push_back(expect_for("decode", z, !legal));
    foreach (steps[i]) trace.push_back(expect_for(steps[i], z, 1'b0));
  endtask

  task automatic checkOutput(input string tag, input obs_t expected);
    n_compared++;
    assert (observed === expected)
    else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed=%05h expected=%05h", tag, observed, expected);
    end
  endtask

  // Runs one whole instruction from FETCH, checking every cycle; returns in the next FETCH
  task automatic applyStimulus(input logic [6:0] opc, input logic z, input string tag);
    op   = opc;
    zero = z;
    build_trace(opc, z);
    #1;
    foreach (trace[k]) begin
      checkOutput($sformatf("%s op=%07b z=%0b step%0d", tag, opc, z, k), trace[k]);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyReset(input int cycles, input string tag);
    rst_n = 1'b0;
    #1;
    checkOutput({tag, " in_reset"},
                mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0));
    repeat (cycles) @(posedge clk);
    #1;
    checkOutput({tag, " held"},
                mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0));
    rst_n = 1'b1;
    #1;
    checkOutput({tag, " released"}, expect_for("fetch", 1'b0, 1'b0));
  endtask

  logic [6:0] legal_ops [7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                7'b1100011, 7'b1101111, 7'b0110111};

  initial begin
    logic [6:0] opc;
    logic       bad;
    op    = 7'b0;
    zero  = 1'b0;
`ifdef MAIN_FSM_MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    #2;
    applyReset(3, "reset");

    applyStimulus(7'b0000011, 1'b0, "lw");
    applyStimulus(7'b1100011, 1'b1, "beq_taken");
    applyStimulus(7'b1100011, 1'b0, "beq_not_taken");
    applyStimulus(7'b0110011, 1'b0, "rtype");
    applyStimulus(7'b0110111, 1'b1, "lui");
    applyStimulus(7'b1111111, 1'b0, "illegal");
    applyStimulus(7'b0100011, 1'b1, "sw");
    applyStimulus(7'b0010011, 1'b0, "itype");
    applyStimulus(7'b1101111, 1'b0, "jal");

    // Abort a load in MEMREAD with an asynchronous reset between clock edges
    op = 7'b0000011;
    repeat (3) @(posedge clk);
    #2;
    applyReset(1, "reset_mid_lw");
    applyStimulus(7'b0110011, 1'b1, "rtype_after_reset");

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) < 7) begin
        opc = legal_ops[$urandom_range(0, 6)];
      end else begin
        do begin
          opc = 7'($urandom_range(0, 127));
          bad = 1'b1;
          foreach (legal_ops[j]) if (legal_ops[j] == opc) bad = 1'b0;
        end while (!bad);
      end
      applyStimulus(opc, 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
    end

`ifdef MAIN_FSM_MEM_WAIT_EN
    // sw stalled 3 cycles in MEMWRITE keeps mem_write high for 4 cycles
    op   = 7'b0100011;
    zero = 1'b0;
    #1;
    checkOutput("wait_sw fetch", expect_for("fetch", 1'b0, 1'b0));
    @(posedge clk); #1;
    checkOutput("wait_sw decode", expect_for("decode", 1'b0, 1'b0));
    @(posedge clk); #1;
    checkOutput("wait_sw memadr", expect_for("memadr", 1'b0, 1'b0));
    mem_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (c == 3) mem_ready = 1'b1;
      #1;
      checkOutput($sformatf("wait_sw memwrite%0d", c), expect_for("memwrite", 1'b0, 1'b0));
    end
    @(posedge clk); #1;
    checkOutput("wait_sw back_to_fetch", expect_for("fetch", 1'b0, 1'b0));

    // Fetch stalls with pc_write/ir_write gated off
    mem_ready = 1'b0;
    #1;
    checkOutput("wait_fetch gated",
                mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0));
    @(posedge clk); #1;
    checkOutput("wait_fetch held",
                mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0));
    mem_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("wait_fetch decode", expect_for("decode", 1'b0, 1'b0));

    // Reset pulsed while stalled in MEMWRITE
    repeat (2) @(posedge clk);
    mem_ready = 1'b0;
    #1;
    checkOutput("wait_rst memwrite", expect_for("memwrite", 1'b0, 1'b0));
    @(posedge clk); #2;
    mem_ready = 1'b1;
    applyReset(1, "reset_mid_wait");
    applyStimulus(7'b0000011, 1'b0, "lw_after_wait_reset");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
